uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range >= 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of 2, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port TX_valid  input  1  write request for the FIFO.
REQ-007 SHALL have port TX_ready  output  1  FIFO not full; a word is accepted on an edge where TX_valid and TX_ready are both high.
REQ-008 SHALL have port TX_data_in  input  DATA_W  word to transmit, LSB sent first.
REQ-009 SHALL have port parity_mode  input  2  parity select: 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port TX_data_out  output  1  registered serial line, idle high.
REQ-012 SHALL have port TX_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-013 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL store accepted words in FIFO order; push while full is ignored; no bypass path when full, even with a simultaneous pop.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with FIFO non-empty, the FSM SHALL pop one word, latch word, parity_mode and stop2, and enter START.
REQ-017 Latency: for a word accepted at edge k into an empty FIFO while the FSM is in IDLE, TX_data_out SHALL be low from edge k+1.
REQ-018 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a bit counter that restarts at every bit boundary.
REQ-019 DATA SHALL shift out DATA_W bits LSB first, then go to PARITY if the latched mode is even/odd, else to STOP.
REQ-020 The parity bit SHALL be XOR of the data bits for even mode and its inverse for odd mode.
REQ-021 STOP SHALL drive 1 for 1 or 2 bit times per latched stop2.
REQ-022 At the end of STOP with the FIFO non-empty, the next START SHALL begin on the immediately following cycle, with no idle gap.
REQ-023 At the end of STOP with the FIFO empty, the FSM SHALL return to IDLE with the line held high.
REQ-024 Changes to parity_mode or stop2 mid-frame SHALL NOT affect the frame in progress.
REQ-025 Frame length SHALL be (1 + DATA_W + P + S) * CLKS_PER_BIT cycles, where P is 0/1 and S is 1/2.
REQ-026 fifo_count SHALL be unchanged on an edge with a simultaneous push and pop.

Reset
REQ-027 While rst is high, the block SHALL force TX_data_out=1, TX_busy=0, TX_ready=1, fifo_count=0, state IDLE, and all counters to 0.
REQ-028 A reset mid-frame SHALL abort the frame, return the line high after the reset edge, and flush the FIFO.

Structure
REQ-029 Package uart_pkg SHALL hold the parity_mode encodings and the FSM state encoding.
REQ-030 The FIFO SHALL be sub-module uart_tx_fifo (parameters DATA_W and FIFO_DEPTH; provides push, pop, full, empty and count).
REQ-031 Baud timing, FSM and shift register SHALL reside in uart_tx_cfg.

Verification (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Push 0xA5, even parity, stop2=0 -> line 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; then TX_busy falls.
REQ-033 Push 0x00, odd parity -> parity bit 1; push 0x07, even parity -> parity bit 1.
REQ-034 Push 0xFF, parity none, stop2=1 -> start bit, 8 ones, then 2 stop bits, 44 cycles total.
REQ-035 Push 6 words on consecutive cycles -> TX_ready falls when fifo_count reaches 4; only 5 words are accepted (1 popped, 4 stored); all frames are contiguous with no idle gap.
REQ-036 Assert rst during DATA bit 3 with 2 words queued -> after the reset edge, TX_data_out=1, TX_busy=0, fifo_count=0, and no further frames are sent.
REQ-037 Toggle parity_mode and stop2 mid-frame -> the current frame is unchanged and the next frame uses the new settings.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - parity_mode_e : encoding of the parity_mode port
//   - tx_state_e    : transmitter FSM state encoding
//   - parity_en()   : does a parity mode append a parity bit
//   - parity_bit()  : value of the parity bit for a data word
// ---------------------------------------------------------------------------
package uart_pkg;

  // Widest data word the parity helper accepts. Narrower words are zero-extended,
  // which leaves their XOR unchanged.
  localparam int unsigned MAX_DATA_W = 9;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // A parity bit is present for even and odd modes only.
  function automatic logic parity_en(input logic [1:0] mode);
    logic en;
    case (parity_mode_e'(mode))
      PAR_EVEN: en = 1'b1;
      PAR_ODD:  en = 1'b1;
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

  // Even mode sends the XOR of the data bits, odd mode sends its inverse.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic [1:0]            mode);
    logic x;
    logic p;
    x = ^data;
    case (parity_mode_e'(mode))
      PAR_EVEN: p = x;
      PAR_ODD:  p = ~x;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO holding words waiting to be serialised.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, empties the FIFO
//   push_i   : write request, ignored while full (even if a pop happens on
//              the same edge)
//   data_i   : word to write
//   pop_i    : read request, ignored while empty
//   data_o   : word at the head of the FIFO (valid when empty_o is low)
//   full_o   : FIFO holds FIFO_DEPTH words
//   empty_o  : FIFO holds no words
//   count_o  : current occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];

  // No bypass: a full FIFO refuses the push regardless of a simultaneous pop.
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Next-state for pointers and occupancy; depth is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so no stale word can ever be observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter with a small input FIFO. Frames are
// start bit (0), DATA_W data bits LSB first, optional parity bit, then one or
// two stop bits (1). Parity mode and stop-bit count are sampled when a word is
// taken from the FIFO, so they are stable for the whole frame.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset; aborts any frame and flushes
//                 the FIFO
//   TX_valid    : write request into the FIFO
//   TX_ready    : FIFO not full; a word is taken when TX_valid && TX_ready
//   TX_data_in  : word to transmit
//   parity_mode : 00 none, 01 even, 10 odd, 11 none
//   stop2       : 0 one stop bit, 1 two stop bits
//   TX_data_out : registered serial line, idle high
//   TX_busy     : frame in progress or FIFO non-empty
//   fifo_count  : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        TX_valid,
  output logic                        TX_ready,
  input  logic [DATA_W-1:0]           TX_data_in,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        TX_data_out,
  output logic                        TX_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  // FIFO interface
  logic              fifo_pop_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;

  // Transmitter state
  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // cycles within the current bit
  logic [IDX_W-1:0]  idx_q, idx_d;      // data bit index, reused as stop bit index
  logic [DATA_W-1:0] shreg_q, shreg_d;  // data shift register, bit 0 is on the line
  logic [1:0]        mode_q, mode_d;    // latched parity mode
  logic              par_q, par_d;      // latched parity bit
  logic              stop2_q, stop2_d;  // latched stop-bit count
  logic              tx_q, tx_d;        // serial line register
  logic              bit_end_s;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (TX_valid),
    .data_i  (TX_data_in),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign TX_ready    = !fifo_full_s;
  assign TX_busy     = (state_q != ST_IDLE) || !fifo_empty_s;
  assign fifo_count  = fifo_count_s;
  assign TX_data_out = tx_q;
  assign bit_end_s   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // FSM next-state, bit timing and next line value. The line register is
  // loaded with the value of the bit that begins on the next edge, so the
  // output is never a cycle behind the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    fifo_pop_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
        end else begin
          fifo_pop_s = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          tx_d    = shreg_q[0];
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          shreg_d = shreg_q >> 1'b1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d = {IDX_W{1'b0}};
            if (parity_en(mode_q)) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1'b1);
            tx_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          tx_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          if (stop2_q && (idx_q == {IDX_W{1'b0}})) begin
            // First of two stop bits done; run the second one.
            idx_d = IDX_W'(1'b1);
            cnt_d = {CNT_W{1'b0}};
            tx_d  = 1'b1;
          end else if (!fifo_empty_s) begin
            // Chain straight into the next start bit, no idle gap.
            fifo_pop_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        tx_d    = 1'b1;
      end
    endcase

    // Frame launch, shared by IDLE and back-to-back STOP: take the head word
    // and sample the line configuration for the whole frame.
    if (fifo_pop_s) begin
      state_d = ST_START;
      cnt_d   = {CNT_W{1'b0}};
      idx_d   = {IDX_W{1'b0}};
      shreg_d = fifo_head_s;
      mode_d  = parity_mode;
      stop2_d = stop2;
      par_d   = parity_bit(MAX_DATA_W'(fifo_head_s), parity_mode);
      tx_d    = 1'b0;
    end else begin
      // Configuration stays frozen between frame launches.
      mode_d  = mode_q;
      stop2_d = stop2_q;
    end
  end

  // Transmitter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      shreg_q <= {DATA_W{1'b0}};
      mode_q  <= 2'b00;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg with DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected line patterns are written out bit by bit (start, data LSB first,
// parity, stops) and expanded to one character per clock cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst;
  logic       TX_valid;
  logic       TX_ready;
  logic [7:0] TX_data_in;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       TX_data_out;
  logic       TX_busy;
  logic [2:0] fifo_count;

  int pass_cnt;
  int total_cnt;

  uart_tx_cfg #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .TX_valid    (TX_valid),
    .TX_ready    (TX_ready),
    .TX_data_in  (TX_data_in),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .TX_data_out (TX_data_out),
    .TX_busy     (TX_busy),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one edge; returns just after that edge.
  task automatic push_word(input logic [7:0] d);
    TX_data_in = d;
    TX_valid   = 1'b1;
    tick();
    TX_valid   = 1'b0;
  endtask

  // Repeat every bit character CPB times: one character per clock cycle.
  function automatic string expand(input string bits);
    string s;
    s = "";
    for (int i = 0; i < bits.len(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        s = {s, bits.substr(i, i)};
      end
    end
    return s;
  endfunction

  // Record the serial line for ncyc cycles, one character per cycle.
  task automatic capture_line(input int ncyc, output string s);
    s = "";
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (TX_data_out === 1'b1) s = {s, "1"};
      else if (TX_data_out === 1'b0) s = {s, "0"};
      else s = {s, "x"};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (TX_data_out !== 1'b1) $display("FAIL reset_line: got %b expected 1", TX_data_out);
    else pass_cnt++;
    total_cnt++;
    if (TX_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", TX_busy);
    else pass_cnt++;
    total_cnt++;
    if (TX_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", TX_ready);
    else pass_cnt++;
    total_cnt++;
    if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_even_parity();
    string obs;
    string exp;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    push_word(8'hA5);
    // Just after the accepting edge: line still high, word queued.
    total_cnt++;
    if (TX_data_out !== 1'b1) $display("FAIL a5_line_at_accept: got %b expected 1", TX_data_out);
    else pass_cnt++;
    total_cnt++;
    if (TX_busy !== 1'b1) $display("FAIL a5_busy_at_accept: got %b expected 1", TX_busy);
    else pass_cnt++;
    total_cnt++;
    if (fifo_count !== 3'd1) $display("FAIL a5_count_at_accept: got %0d expected 1", fifo_count);
    else pass_cnt++;
    capture_line(44, obs);
    exp = expand("01010010101");
    total_cnt++;
    if (obs != exp) $display("FAIL a5_even_line: got %s expected %s", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (TX_busy !== 1'b1) $display("FAIL a5_busy_last_stop: got %b expected 1", TX_busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (TX_busy !== 1'b0 || TX_data_out !== 1'b1)
      $display("FAIL a5_idle_after: got busy=%b line=%b expected busy=0 line=1", TX_busy, TX_data_out);
    else pass_cnt++;
  endtask

  task automatic test_parity_bits();
    logic [7:0] data_t [3];
    logic [1:0] mode_t [3];
    string      bits_t [3];
    string      obs;
    string      exp;
    data_t[0] = 8'h00; mode_t[0] = 2'b10; bits_t[0] = "00000000011";  // odd -> 1
    data_t[1] = 8'h07; mode_t[1] = 2'b01; bits_t[1] = "01110000011";  // even -> 1
    data_t[2] = 8'h5A; mode_t[2] = 2'b11; bits_t[2] = "0010110101";   // 11 = none
    stop2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      parity_mode = mode_t[i];
      push_word(data_t[i]);
      capture_line(bits_t[i].len() * CPB, obs);
      exp = expand(bits_t[i]);
      total_cnt++;
      if (obs != exp) $display("FAIL parity_line_%0d: got %s expected %s", i, obs, exp);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (TX_busy !== 1'b0) $display("FAIL parity_end_%0d: busy got %b expected 0", i, TX_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_two_stop();
    string obs;
    string exp;
    parity_mode = 2'b00;
    stop2       = 1'b1;
    push_word(8'hFF);
    capture_line(44, obs);
    exp = expand("01111111111");
    total_cnt++;
    if (obs != exp) $display("FAIL ff_stop2_line: got %s expected %s", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (TX_busy !== 1'b1) $display("FAIL ff_busy_cycle44: got %b expected 1", TX_busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (TX_busy !== 1'b0) $display("FAIL ff_busy_cycle45: got %b expected 0", TX_busy);
    else pass_cnt++;
    stop2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    logic [2:0] exp_cnt [6];
    logic       exp_rdy [6];
    string      obs;
    string      exp;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
    // Occupancy after each accepting edge: word 0 is popped while word 1
    // arrives (count holds at 1), word 5 meets a full FIFO and is dropped.
    exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
    exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4; exp_cnt[5] = 3'd4;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
    exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b0;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    exp = expand({"0100010001", "0010001001", "0110011001", "0001000101", "0101010101"});
    TX_data_in = words[0];
    TX_valid   = 1'b1;
    tick();
    total_cnt++;
    if (fifo_count !== exp_cnt[0] || TX_ready !== exp_rdy[0])
      $display("FAIL b2b_fill_0: got count=%0d ready=%b expected count=%0d ready=%b",
               fifo_count, TX_ready, exp_cnt[0], exp_rdy[0]);
    else pass_cnt++;
    fork
      capture_line(200, obs);
      begin
        for (int j = 1; j < 6; j++) begin
          TX_data_in = words[j];
          tick();
          total_cnt++;
          if (fifo_count !== exp_cnt[j] || TX_ready !== exp_rdy[j])
            $display("FAIL b2b_fill_%0d: got count=%0d ready=%b expected count=%0d ready=%b",
                     j, fifo_count, TX_ready, exp_cnt[j], exp_rdy[j]);
          else pass_cnt++;
        end
        TX_valid = 1'b0;
      end
    join
    total_cnt++;
    if (obs != exp) $display("FAIL b2b_line: got %s expected %s", obs, exp);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (TX_busy !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL b2b_drained: got busy=%b count=%0d expected busy=0 count=0", TX_busy, fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_cfg_change();
    string obs;
    string exp;
    parity_mode = 2'b01;
    stop2       = 1'b0;
    // Frame 1: 0xA5 even, one stop. Frame 2: 0x00 odd, two stops.
    exp = expand({"01010010101", "000000000111"});
    push_word(8'hA5);
    fork
      capture_line(92, obs);
      begin
        TX_data_in = 8'h00;
        TX_valid   = 1'b1;
        tick();
        TX_valid   = 1'b0;
        repeat (8) tick();
        parity_mode = 2'b10;
        stop2       = 1'b1;
      end
    join
    total_cnt++;
    if (obs != exp) $display("FAIL cfg_change_line: got %s expected %s", obs, exp);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (TX_busy !== 1'b0) $display("FAIL cfg_change_end: busy got %b expected 0", TX_busy);
    else pass_cnt++;
    parity_mode = 2'b00;
    stop2       = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic quiet;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    TX_valid    = 1'b1;
    TX_data_in  = 8'hF7;  // bit 3 is 0, so the reset visibly raises the line
    tick();
    TX_data_in  = 8'h12;
    tick();
    TX_data_in  = 8'h34;
    tick();
    TX_valid    = 1'b0;
    total_cnt++;
    if (fifo_count !== 3'd2) $display("FAIL rstmid_queued: got %0d expected 2", fifo_count);
    else pass_cnt++;
    repeat (16) tick();  // now in the second cycle of data bit 3
    total_cnt++;
    if (TX_data_out !== 1'b0) $display("FAIL rstmid_bit3: got %b expected 0", TX_data_out);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (TX_data_out !== 1'b1 || TX_busy !== 1'b0 || fifo_count !== 3'd0 || TX_ready !== 1'b1)
      $display("FAIL rstmid_after: got line=%b busy=%b count=%0d ready=%b expected 1 0 0 1",
               TX_data_out, TX_busy, fifo_count, TX_ready);
    else pass_cnt++;
    rst   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (TX_data_out !== 1'b1 || TX_busy !== 1'b0) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("FAIL rstmid_no_frames: got quiet=%b expected 1", quiet);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    rst         = 1'b1;
    TX_valid    = 1'b0;
    TX_data_in  = 8'h00;
    parity_mode = 2'b00;
    stop2       = 1'b0;
    test_reset();
    test_even_parity();
    test_parity_bits();
    test_two_stop();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
